fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage 16-bit RISC pipeline, directly upstream of decode. It owns the program counter, reads instruction memory, and assembles two-word (immediate) instructions. It also handles stall, flush, jump and memory-loaded PC redirects, and injects interrupt bubbles. Its registered IF/ID outputs drive decode's `instruction`, `PC` and `interrupt_signal` inputs.

## Interface
- `PC_WIDTH`, 32, width of the program counter and all PC buses
- `RESET_VECTOR`, 32'h0, PC value after reset
- `clk` input 1: single clock, rising edge
- `reset` input 1: synchronous, active-low
- `stall` input 1: hazard hold; freezes PC, FSM and IF/ID
- `flush` input 1: replace the next IF/ID contents with a NOP
- `jump_taken` input 1: redirect PC to `jump_target`
- `jump_target` input PC_WIDTH: jump destination
- `pc_load_mem` input 1: redirect PC to `pc_from_memory` (RET/RTI/interrupt vector); highest-priority redirect
- `pc_from_memory` input PC_WIDTH: PC value read from data memory
- `interrupt_in` input 1: external interrupt request, level or pulse
- `imem_addr` output PC_WIDTH: instruction memory address, equal to the PC register (combinational)
- `imem_data` input 16: instruction word; combinational read valid in the same cycle
- `instruction_r` output 16: IF/ID instruction word
- `immediate_r` output 16: IF/ID immediate; valid only for two-word instructions
- `pc_r` output PC_WIDTH: IF/ID resume PC, the address of the word after this instruction
- `interrupt_signal_r` output 1: IF/ID interrupt bubble marker

## Operation
- An instruction is two-word when `imem_data[15:14]==2'b11`. The second word is the 16-bit immediate.
- FSM states:
  - **FETCH**: PC increments by 1 each cycle.
    - One-word instruction: IF/ID receives {instr, imm=0, pc_r=PC+1}.
    - Two-word instruction: the first word is latched into `hold_q` and the FSM moves to FETCH_IMM. IF/ID receives a NOP bubble this cycle.
  - **FETCH_IMM**: IF/ID receives {`hold_q`, `imem_data`, PC+1}, PC increments by 1, and the FSM returns to FETCH.
  - **INT_BUBBLE** (present only with the interrupt macro): IF/ID receives {NOP, 0, pc_r=PC, interrupt_signal_r=1}. PC holds. The FSM returns to FETCH.
- Interrupts:
  - A rising or high `interrupt_in` sets `int_pending`.
  - `int_pending` is serviced only in FETCH, never mid two-word instruction. Servicing means entering INT_BUBBLE instead of fetching, and clearing `int_pending`.
  - Requests arriving while `int_pending` is already set merge into it.
- Per-cycle priority:
  1. `reset`
  2. `pc_load_mem`
  3. `jump_taken`
  4. `stall`
  5. normal operation
- On a redirect (`pc_load_mem` or `jump_taken`):
  - PC is set to the target and the FSM goes to FETCH; this abandons a partial FETCH_IMM.
  - IF/ID receives a NOP.
  - `int_pending` is kept.
- Flush and stall:
  - `flush` without a redirect: IF/ID receives a NOP; PC and FSM still advance normally.
  - `stall` without a redirect or flush: PC, FSM, `hold_q` and IF/ID all hold.
  - `flush` together with `stall`: the flush wins for IF/ID only; PC and FSM hold.
- NOP = `instruction_r` 16'h0000, `immediate_r` 0, `interrupt_signal_r` 0. `pc_r` keeps the PC value computed for that cycle.
- PC arithmetic is modulo 2^PC_WIDTH: PC 32'hFFFF_FFFF + 1 wraps to 0 with no flag.

## Timing
- Reset values: PC=`RESET_VECTOR`, FSM=FETCH, `hold_q`=0, `int_pending`=0, `instruction_r`=0, `immediate_r`=0, `pc_r`=0, `interrupt_signal_r`=0.
- `imem_addr` follows PC combinationally and equals `RESET_VECTOR` in the first cycle after reset deasserts.
- Latency:
  - One-word instruction: appears in IF/ID one clock after its address is presented.
  - Two-word instruction: appears two clocks after its first address, preceded by one NOP cycle.
- Redirects take effect on the next edge; the first target instruction reaches IF/ID one clock after that.
- Interrupt:
  - The bubble reaches IF/ID one cycle after being serviced in FETCH.
  - Worst case, servicing is delayed one extra cycle if the request lands in FETCH_IMM.
- Asserting `reset` mid-operation discards the partial instruction and any pending interrupt in that cycle.

## Configuration
- `FETCH_INTERRUPT_EN` defined: `int_pending` and the INT_BUBBLE state are compiled in, and interrupts work as described above.
- `FETCH_INTERRUPT_EN` undefined:
  - `interrupt_in` is ignored.
  - `interrupt_signal_r` is tied to 0.
  - The FSM has only FETCH and FETCH_IMM.
  - Jump, stall and flush behaviour is unchanged.

## Test plan
- Reset then sequential one-word fetch, memory word n = 16'h1000+n: `imem_addr` reads 0,1,2. IF/ID shows 16'h1000/`pc_r`=1, then 16'h1001/`pc_r`=2.
- Two-word instruction, mem[4]=16'hC200, mem[5]=16'h00AB: IF/ID shows a NOP cycle, then `instruction_r`=16'hC200, `immediate_r`=16'h00AB, `pc_r`=6.
- `jump_taken`=1 with target 0x40 during FETCH_IMM: the partial instruction is dropped, IF/ID shows a NOP, next `imem_addr`=0x40. With `pc_load_mem`=1 (value 0x80) asserted in the same cycle, PC goes to 0x80.
- `stall` held 3 cycles at PC=7: `imem_addr` stays 7 and IF/ID is unchanged. Adding `flush` in cycle 2: IF/ID becomes NOP while PC stays 7.
- Interrupt pulse at PC=10 in FETCH: the next IF/ID is a bubble with `interrupt_signal_r`=1 and `pc_r`=10, and PC holds at 10. The same pulse during FETCH_IMM is serviced after the immediate completes.
- Wrap test, PC forced to 32'hFFFF_FFFF via `pc_load_mem`: the next `imem_addr` is 0. With the macro undefined, an interrupt pulse leaves `interrupt_signal_r`=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage; owns PC, reads imem, joins two-word instrs, emits IF/ID.
// Ports: ctl(stall/flush/jump/pc_load_mem/irq) -> imem_addr/imem_data -> IF/ID regs; opt FETCH_INTERRUPT_EN.
module fetch_stage #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                jump_taken,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                pc_load_mem,
  input  logic [PC_WIDTH-1:0] pc_from_memory,
  input  logic                interrupt_in,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  output logic [15:0]         instruction_r,
  output logic [15:0]         immediate_r,
  output logic [PC_WIDTH-1:0] pc_r,
  output logic                interrupt_signal_r
);

  localparam logic [15:0] NOP = 16'h0000;

`ifdef FETCH_INTERRUPT_EN
  typedef enum logic [1:0] {
    FETCH,
    FETCH_IMM,
    INT_BUBBLE
  } state_t;

  logic int_pending;
  logic int_req;

  // A request in the current cycle is serviceable at once.
  assign int_req = int_pending | interrupt_in;
`else
  typedef enum logic {
    FETCH,
    FETCH_IMM
  } state_t;

  logic unused_interrupt;

  assign unused_interrupt = interrupt_in;
`endif

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [15:0]         hold_q;
  logic                two_word;
  logic                redirect;
  logic                hold;
  logic                run;

  assign imem_addr   = pc_q;
  assign pc_inc      = pc_q + PC_WIDTH'(1);
  assign two_word    = imem_data[15:14] == 2'b11;
  assign redirect    = pc_load_mem | jump_taken;
  assign redirect_pc = pc_load_mem ? pc_from_memory
                                   : jump_target;
  assign hold        = !redirect && stall;
  assign run         = !redirect && !stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q               <= RESET_VECTOR;
      state_q            <= FETCH;
      hold_q             <= '0;
      instruction_r      <= NOP;
      immediate_r        <= '0;
      pc_r               <= '0;
      interrupt_signal_r <= 1'b0;
`ifdef FETCH_INTERRUPT_EN
      int_pending        <= 1'b0;
`endif
    end else begin
`ifdef FETCH_INTERRUPT_EN
      // Servicing below overrides this set.
      if (interrupt_in)
        int_pending <= 1'b1;
`endif
      unique case (1'b1)
        redirect: begin
          pc_q               <= redirect_pc;
          state_q            <= FETCH;
          instruction_r      <= NOP;
          immediate_r        <= '0;
          pc_r               <= redirect_pc;
          interrupt_signal_r <= 1'b0;
        end
        hold: begin
          if (flush) begin
            instruction_r      <= NOP;
            immediate_r        <= '0;
            pc_r               <= pc_q;
            interrupt_signal_r <= 1'b0;
          end
        end
        run: begin
          unique case (state_q)
            FETCH: begin
`ifdef FETCH_INTERRUPT_EN
              if (int_req) begin
                int_pending        <= 1'b0;
                state_q            <= INT_BUBBLE;
                instruction_r      <= NOP;
                immediate_r        <= '0;
                pc_r               <= pc_q;
                interrupt_signal_r <= 1'b0;
              end else
`endif
              if (two_word) begin
                hold_q             <= imem_data;
                state_q            <= FETCH_IMM;
                pc_q               <= pc_inc;
                instruction_r      <= NOP;
                immediate_r        <= '0;
                pc_r               <= pc_inc;
                interrupt_signal_r <= 1'b0;
              end else begin
                pc_q               <= pc_inc;
                instruction_r      <= imem_data;
                immediate_r        <= '0;
                pc_r               <= pc_inc;
                interrupt_signal_r <= 1'b0;
              end
            end
            FETCH_IMM: begin
              state_q            <= FETCH;
              pc_q               <= pc_inc;
              instruction_r      <= hold_q;
              immediate_r        <= imem_data;
              pc_r               <= pc_inc;
              interrupt_signal_r <= 1'b0;
            end
`ifdef FETCH_INTERRUPT_EN
            INT_BUBBLE: begin
              state_q            <= FETCH;
              instruction_r      <= NOP;
              immediate_r        <= '0;
              pc_r               <= pc_q;
              interrupt_signal_r <= 1'b1;
            end
`endif
            default: state_q <= FETCH;
          endcase
          // Flush only blanks IF/ID; pc_r keeps this cycle's value.
          if (flush) begin
            instruction_r      <= NOP;
            immediate_r        <= '0;
            interrupt_signal_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
